// File: rtl/sr_drv_pkg.sv
// -----------------------------------------------------------------------------
// sr_drv_pkg
// Shared types for the SR latch pulse driver:
//   - FSM state encodings (3-bit) and the matching state enum
//   - request-kind encoding used by the single-deep pending slot
//   - request struct plus a decode helper (clear has priority over set)
//   - small integer max helper used to size the phase counter
// -----------------------------------------------------------------------------
package sr_drv_pkg;

  // FSM state encodings
  localparam logic [2:0] ENC_INIT    = 3'd0;
  localparam logic [2:0] ENC_IDLE    = 3'd1;
  localparam logic [2:0] ENC_PULSE_S = 3'd2;
  localparam logic [2:0] ENC_PULSE_R = 3'd3;
  localparam logic [2:0] ENC_GAP     = 3'd4;

  typedef enum logic [2:0] {
    ST_INIT    = ENC_INIT,
    ST_IDLE    = ENC_IDLE,
    ST_PULSE_S = ENC_PULSE_S,
    ST_PULSE_R = ENC_PULSE_R,
    ST_GAP     = ENC_GAP
  } drv_state_e;

  // Request kind held in the pending slot
  typedef enum logic {
    REQ_SET = 1'b0,
    REQ_CLR = 1'b1
  } req_kind_e;

  typedef struct packed {
    logic      vld;
    req_kind_e kind;
  } req_t;

  // Both strobes in the same cycle collapse to a clear.
  function automatic req_t decode_req(input logic set_req, input logic clr_req);
    req_t r;
    r.vld  = set_req | clr_req;
    r.kind = clr_req ? REQ_CLR : REQ_SET;
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// 1-bit two-flop synchronizer for a signal asynchronous to clk.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, both flops clear to 0
//   i_d  - asynchronous input
//   o_q  - synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/sr_pulse_driver.sv
// -----------------------------------------------------------------------------
// sr_pulse_driver
// Clocked driver for a NOR SR latch. Converts one-cycle set/clear strobes into
// registered, mutually exclusive S/R pulses of PULSE_W cycles, each followed by
// GAP_W cycles with both lines low. After reset an automatic clear pulse puts
// the latch in a known state. The latch Q is synchronized and compared against
// the expected state at the end of every gap; mismatches set a sticky flag.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   set_req   - one-cycle strobe, request latch set
//   clr_req   - one-cycle strobe, request latch clear (wins over set_req)
//   q_fb      - latch Q feedback, asynchronous to clk
//   err_clr   - clears fb_err (a coincident new mismatch wins)
//   S, R      - registered latch drives, never both high
//   busy      - registered, high while a pulse/gap is running or pending
//   state_exp - expected latch state, updated on the first cycle of a pulse
//   fb_err    - sticky feedback mismatch flag
// PULSE_W + GAP_W must be >= 3 so the synchronized Q reflects the pulse by the
// time the end-of-gap comparison is made.
// -----------------------------------------------------------------------------
module sr_pulse_driver #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  input  logic err_clr,
  output logic S,
  output logic R,
  output logic busy,
  output logic state_exp,
  output logic fb_err
);
  import sr_drv_pkg::*;

  localparam int CNT_W = $clog2(max_int(PULSE_W, GAP_W)) + 1;
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

  drv_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  req_t             r_pend;

  req_t      w_req;
  logic      w_q_sync;
  logic      w_gap_end;
  logic      w_launch;
  req_kind_e w_launch_kind;
  logic      w_pend_cap;

  sync_2ff u_sync_q (
    .clk (clk),
    .rst (rst),
    .i_d (q_fb),
    .o_q (w_q_sync)
  );

  assign w_req     = decode_req(set_req, clr_req);
  assign w_gap_end = (r_state == ST_GAP) && (r_cnt == '0);

  // A request arriving while busy is parked, except on the last gap cycle
  // where it launches directly at the next edge.
  assign w_pend_cap = w_req.vld && (r_state != ST_IDLE) && !w_gap_end;

  // Decide whether a pulse starts at this edge and which kind. A fresh
  // request on the last gap cycle is newer than the parked one, so it wins.
  always_comb begin
    w_launch      = 1'b0;
    w_launch_kind = REQ_CLR;
    case (r_state)
      ST_INIT: begin
        w_launch      = 1'b1;
        w_launch_kind = REQ_CLR;
      end
      ST_IDLE: begin
        w_launch      = w_req.vld;
        w_launch_kind = w_req.kind;
      end
      ST_GAP: begin
        if (w_gap_end) begin
          w_launch      = w_req.vld | r_pend.vld;
          w_launch_kind = w_req.vld ? w_req.kind : r_pend.kind;
        end
      end
      default: begin
        w_launch      = 1'b0;
        w_launch_kind = REQ_CLR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_INIT;
      r_cnt     <= '0;
      r_pend    <= '0;
      S         <= 1'b0;
      R         <= 1'b0;
      busy      <= 1'b1;
      state_exp <= 1'b0;
      fb_err    <= 1'b0;
    end else begin
      // Sticky error: a new mismatch takes precedence over err_clr.
      if (w_gap_end && (w_q_sync != state_exp))
        fb_err <= 1'b1;
      else if (err_clr)
        fb_err <= 1'b0;

      if (w_launch) begin
        r_state    <= (w_launch_kind == REQ_SET) ? ST_PULSE_S : ST_PULSE_R;
        r_cnt      <= PULSE_LD;
        S          <= (w_launch_kind == REQ_SET);
        R          <= (w_launch_kind == REQ_CLR);
        state_exp  <= (w_launch_kind == REQ_SET);
        busy       <= 1'b1;
        r_pend.vld <= 1'b0;
      end else begin
        case (r_state)
          ST_PULSE_S, ST_PULSE_R: begin
            if (r_cnt == '0) begin
              r_state <= ST_GAP;
              r_cnt   <= GAP_LD;
              S       <= 1'b0;
              R       <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_GAP: begin
            // Gap end with nothing to launch: pending slot is empty here.
            if (r_cnt == '0) begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end

      // Latest request overwrites the slot; placed after the launch clear so a
      // request seen during INIT is kept for after the automatic clear.
      if (w_pend_cap)
        r_pend <= w_req;
    end
  end

endmodule

// File: tb/tb_sr_pulse_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_pulse_driver
// Directed bench for sr_pulse_driver (PULSE_W=4, GAP_W=2) with a behavioural
// NOR latch model on the outputs feeding q_fb (optionally tied low).
// -----------------------------------------------------------------------------
module tb_sr_pulse_driver;

  logic clk = 1'b0;
  logic rst;
  logic set_req, clr_req, err_clr;
  logic q_fb;
  logic S, R, busy, state_exp, fb_err;

  logic q_lat;
  logic fb_tie;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // NOR latch behaviour: S sets, R clears, otherwise hold.
  always_latch begin
    if (S)      q_lat <= 1'b1;
    else if (R) q_lat <= 1'b0;
  end

  assign q_fb = fb_tie ? 1'b0 : q_lat;

  sr_pulse_driver #(.PULSE_W(4), .GAP_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .set_req   (set_req),
    .clr_req   (clr_req),
    .q_fb      (q_fb),
    .err_clr   (err_clr),
    .S         (S),
    .R         (R),
    .busy      (busy),
    .state_exp (state_exp),
    .fb_err    (fb_err)
  );

  typedef struct {
    logic s, c, e;
    logic xs, xr, xb, xse, xfb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic s, input logic c, input logic e,
                     input logic xs, input logic xr, input logic xb,
                     input logic xse, input logic xfb);
    vec_t v;
    v.s = s; v.c = c; v.e = e;
    v.xs = xs; v.xr = xr; v.xb = xb; v.xse = xse; v.xfb = xfb;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // Advance to the next cycle, drive inputs just after the edge, then wait
  // until mid-cycle so outputs can be sampled.
  task automatic cyc(input logic r, input logic s, input logic c, input logic e);
    @(posedge clk);
    #1;
    rst = r; set_req = s; clr_req = c; err_clr = e;
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic xs, input logic xr,
                         input logic xb, input logic xse, input logic xfb);
    chk({tag, "_S"}, S, xs);
    chk({tag, "_R"}, R, xr);
    chk({tag, "_busy"}, busy, xb);
    chk({tag, "_state_exp"}, state_exp, xse);
    chk({tag, "_fb_err"}, fb_err, xfb);
  endtask

  // S and R must never be high together.
  always @(negedge clk) begin
    if (rst === 1'b0) chk("s_r_exclusive", S & R, 1'b0);
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; set_req = 1'b0; clr_req = 1'b0; err_clr = 1'b0; fb_tie = 1'b0;

    // Reset release, set, simultaneous strobes, pending overwrite,
    // request on the last gap cycle. Row index = cycle after reset release.
    add(1, 0,0,0, 0,0,1,0,0);  // c0  INIT
    add(4, 0,0,0, 0,1,1,0,0);  // c1-4 auto clear
    add(2, 0,0,0, 0,0,1,0,0);  // c5-6 gap
    add(1, 0,0,0, 0,0,0,0,0);  // c7  idle
    add(1, 1,0,0, 0,0,0,0,0);  // c8  set_req
    add(4, 0,0,0, 1,0,1,1,0);  // c9-12
    add(2, 0,0,0, 0,0,1,1,0);  // c13-14
    add(1, 0,0,0, 0,0,0,1,0);  // c15
    add(1, 1,1,0, 0,0,0,1,0);  // c16 both strobes -> clear
    add(4, 0,0,0, 0,1,1,0,0);  // c17-20
    add(2, 0,0,0, 0,0,1,0,0);  // c21-22
    add(1, 0,0,0, 0,0,0,0,0);  // c23
    add(1, 1,0,0, 0,0,0,0,0);  // c24 set (t)
    add(1, 0,0,0, 1,0,1,1,0);  // c25
    add(1, 1,0,0, 1,0,1,1,0);  // c26 set pended
    add(1, 0,1,0, 1,0,1,1,0);  // c27 clr overwrites
    add(1, 0,0,0, 1,0,1,1,0);  // c28
    add(2, 0,0,0, 0,0,1,1,0);  // c29-30
    add(4, 0,0,0, 0,1,1,0,0);  // c31-34 pended clear
    add(2, 0,0,0, 0,0,1,0,0);  // c35-36
    add(2, 0,0,0, 0,0,0,0,0);  // c37-38 no third pulse
    add(1, 1,0,0, 0,0,0,0,0);  // c39 set
    add(4, 0,0,0, 1,0,1,1,0);  // c40-43
    add(1, 0,0,0, 0,0,1,1,0);  // c44
    add(1, 0,1,0, 0,0,1,1,0);  // c45 clr on last gap cycle
    add(4, 0,0,0, 0,1,1,0,0);  // c46-49 starts with no idle cycle
    add(2, 0,0,0, 0,0,1,0,0);  // c50-51
    add(1, 0,0,0, 0,0,0,0,0);  // c52

    cyc(1, 0,0,0);
    chk_all("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1, 0,0,0);
    cyc(1, 0,0,0);

    foreach (tbl[i]) begin
      cyc(1'b0, tbl[i].s, tbl[i].c, tbl[i].e);
      chk_all($sformatf("row%0d", i), tbl[i].xs, tbl[i].xr, tbl[i].xb,
              tbl[i].xse, tbl[i].xfb);
    end

    // Feedback fault: q_fb held low while setting.
    fb_tie = 1'b1;
    cyc(0, 1,0,0);                              // t
    for (int k = 1; k <= 7; k++) cyc(0, 0,0,0); // t+7
    chk("fb_set_t7", fb_err, 1'b1);
    chk("fb_set_busy", busy, 1'b0);
    cyc(0, 0,0,0); chk("fb_sticky_t8", fb_err, 1'b1);
    cyc(0, 0,0,0); chk("fb_sticky_t9", fb_err, 1'b1);
    cyc(0, 0,0,1); chk("fb_clr_t10", fb_err, 1'b1);
    cyc(0, 0,0,0); chk("fb_cleared_t11", fb_err, 1'b0);
    cyc(0, 1,0,0);                              // t+12 refresh set
    for (int k = 1; k <= 7; k++) cyc(0, 0,0,0); // t+19
    chk("fb_reset_again", fb_err, 1'b1);
    chk("refresh_state_exp", state_exp, 1'b1);
    cyc(0, 1,0,0);                              // t+20
    for (int k = 1; k <= 5; k++) cyc(0, 0,0,0); // t+25
    cyc(0, 0,0,1);                              // t+26 last gap + err_clr
    cyc(0, 0,0,0); chk("fb_set_beats_clr", fb_err, 1'b1);
    cyc(0, 0,0,1);
    cyc(0, 0,0,0); chk("fb_final_clear", fb_err, 1'b0);
    fb_tie = 1'b0;

    // Reset in the middle of an S pulse with a request pending.
    cyc(0, 1,0,0);                              // t
    cyc(0, 0,1,0); chk("mid_S_t1", S, 1'b1);    // clear gets pended
    cyc(1, 0,0,0); chk("mid_S_t2", S, 1'b1);    // reset sampled at end
    cyc(0, 0,0,0);
    chk_all("mid_rst_t3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 4; k <= 7; k++) begin
      cyc(0, 0,0,0);
      chk($sformatf("mid_init_R_t%0d", k), R, 1'b1);
      chk($sformatf("mid_init_S_t%0d", k), S, 1'b0);
    end
    cyc(0, 0,0,0); chk("mid_gap_t8", R, 1'b0);
    cyc(0, 0,0,0); chk("mid_gap_t9", busy, 1'b1);
    cyc(0, 0,0,0);
    chk_all("mid_idle_t10", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(0, 0,0,0);
    chk_all("mid_idle_t11", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sr_pulse_driver.md
Name: sr_pulse_driver

Overview:
Clocked upstream driver for the NOR SR latch (sr_latch_nor). It turns one-cycle set/clear request strobes into registered, mutually exclusive S/R pulses with a guaranteed width and a both-low guard gap. It never drives S=R=1 and never releases 1,1 to 0,0. It also runs an automatic clear pulse after reset so the latch starts in a defined state, and checks the latch Q feedback against the expected state.

Parameters:
PULSE_W, 4, cycles S or R is held high per pulse (>=1)
GAP_W, 2, cycles both S and R are low after each pulse (>=1); PULSE_W+GAP_W must be >=3
CNT_W (localparam), $clog2(max(PULSE_W,GAP_W))+1, width of the shared phase counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
set_req  in  1  one-cycle strobe: request latch set
clr_req  in  1  one-cycle strobe: request latch clear
q_fb  in  1  latch Q feedback, asynchronous to clk
err_clr  in  1  clears fb_err
S  out  1  latch set drive, registered
R  out  1  latch reset drive, registered
busy  out  1  FSM not IDLE or a request is pending
state_exp  out  1  expected latch state
fb_err  out  1  sticky feedback-mismatch flag

Behaviour:
- Reset (rst=1 at an edge): S=0, R=0, state_exp=0, fb_err=0, pending cleared, counter=0, FSM enters INIT. busy=1 while in INIT.
- FSM states: INIT, IDLE, PULSE_S, PULSE_R, GAP.
  - INIT: on the first edge with rst=0, go to PULSE_R. This is the automatic clear; state_exp=0.
  - IDLE: on a sampled request, go to PULSE_S or PULSE_R.
  - PULSE_S / PULSE_R: last exactly PULSE_W cycles, then go to GAP.
  - GAP: lasts exactly GAP_W cycles. Then go to the pending pulse state if one exists (pending cleared), else IDLE.
- Latency: a request high in cycle t while IDLE gives S (or R) high in cycles t+1..t+PULSE_W and a gap in t+PULSE_W+1..t+PULSE_W+GAP_W.
- busy is registered: high t+1..t+PULSE_W+GAP_W, low the next cycle if nothing is pending.
- state_exp updates in the first cycle of each pulse: 1 for S, 0 for R.
- Simultaneous set_req and clr_req: treated as clr only (clear priority).
- Requests while not IDLE go to a single-deep pending slot; a newer request overwrites it (latest wins). A request in the last GAP cycle is pended and starts the next cycle with no extra idle cycle.
- A request matching state_exp is still issued (refresh pulse), not suppressed.
- Invariant: S and R are never both 1 in any cycle. Any transition between S-high and R-high passes through at least GAP_W both-low cycles.
- q_fb passes through a 2-flop synchronizer before use.
  - At the edge ending the last GAP cycle, if synced q_fb != state_exp, fb_err is set; visible in the cycle after the gap.
  - fb_err is sticky until err_clr. If err_clr coincides with a new mismatch, set wins.
- Reset mid-operation: S/R drop to 0 at the reset edge and the pending request is discarded. After release, the full INIT clear sequence runs again.
- The counter counts down from PULSE_W-1 / GAP_W-1 and never wraps; its terminal value is 0.

Decomposition:
- Package sr_drv_pkg holds the FSM state encodings (3-bit localparams: INIT, IDLE, PULSE_S, PULSE_R, GAP) and the request-kind encoding (REQ_SET, REQ_CLR) for the pending slot.
- One sub-module: sync_2ff (1-bit two-flop synchronizer, synchronous active-high reset to 0) for q_fb.
- The FSM, counter, pending slot and error flag live in sr_pulse_driver.

Test Plan:
All scenarios use PULSE_W=4 and GAP_W=2, with sr_latch_nor instantiated behind the driver for q_fb (except where tied off).
1. Reset release: rst=1 for 3 cycles, released before cycle 0 -> R=1 in cycles 1..4, S=R=0 in 5..6, busy=0 from 7, state_exp=0, fb_err=0.
2. Set: set_req in cycle t while IDLE -> S=1 t+1..t+4, R=0 throughout, state_exp=1 from t+1, busy=0 at t+7, latch Q=1, fb_err=0.
3. Simultaneous strobes: set_req=clr_req=1 in cycle t -> only R=1 t+1..t+4, S=0 throughout, state_exp=0.
4. Pending overwrite: set_req at t, set_req at t+2, clr_req at t+3 -> S t+1..t+4, gap t+5..t+6, R t+7..t+10, no third pulse, busy=0 at t+13.
5. Feedback fault: q_fb tied to 0, set_req at t -> fb_err=1 at t+7 and stays high; err_clr pulse at t+10 -> fb_err=0 at t+11; err_clr at the same edge as a new mismatch -> fb_err stays 1.
6. Reset mid-pulse and invariant: rst in cycle t+2 of an S pulse -> S=0 from t+3, pending discarded, INIT R sequence after release. A bench assertion that S&R==0 in every cycle runs across all scenarios.
